// File: rtl/addsub_op_sequencer_pkg.sv
// Shared types and constants for the add/sub operation sequencer.
package addsub_op_sequencer_pkg;

  localparam int unsigned SEQ_WIDTH = 8;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic c;
    logic v;
    logic z;
    logic n;
  } flags_t;

endpackage

// File: rtl/addsub_op_sequencer_flag_calc.sv
// Combinational status flags for one adder result: carry passes through,
// overflow/zero/negative derived from operands and sum.
module addsub_flag_calc
  import addsub_op_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = SEQ_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] beff,
  input  logic [WIDTH-1:0] s,
  input  logic             cout,
  output flags_t           flags
);

  always_comb begin
    flags   = '0;
    flags.c = cout;
    // Overflow: operands agree in sign but the sum does not.
    flags.v = (a[WIDTH-1] == beff[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    flags.z = (s == '0);
    flags.n = s[WIDTH-1];
  end

endmodule

// File: rtl/addsub_op_sequencer.sv
// Valid/ready sequencer around an external 8-bit adder/subtractor.
// Optional accumulator feature enabled by defining ADDSUB_SEQ_ACC_EN.
module addsub_op_sequencer
  import addsub_op_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = SEQ_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  input  logic             op_acc,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_s,
  output logic             res_c,
  output logic             res_v,
  output logic             res_z,
  output logic             res_n
);

  seq_state_t       state;
  logic [WIDTH-1:0] beff;
  flags_t           flags;
  logic [WIDTH-1:0] a_src;

  // The adder inverts B internally; mirror that here for the overflow rule.
  assign beff = add_b ^ {WIDTH{add_cin}};

  addsub_flag_calc #(
    .WIDTH(WIDTH)
  ) u_flag_calc (
    .a    (add_a),
    .beff (beff),
    .s    (add_s),
    .cout (add_cout),
    .flags(flags)
  );

`ifdef ADDSUB_SEQ_ACC_EN
  logic [WIDTH-1:0] acc;

  assign a_src = op_acc ? acc : op_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (state == EXEC) begin
      acc <= add_s;
    end
  end
`else
  logic unused_op_acc;

  assign unused_op_acc = op_acc;
  assign a_src         = op_a;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_ready  <= 1'b1;
      add_a     <= '0;
      add_b     <= '0;
      add_cin   <= MODE_ADD;
      res_valid <= 1'b0;
      res_s     <= '0;
      res_c     <= 1'b0;
      res_v     <= 1'b0;
      res_z     <= 1'b0;
      res_n     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            add_a    <= a_src;
            add_b    <= op_b;
            add_cin  <= op_sub;
            op_ready <= 1'b0;
            state    <= EXEC;
          end
        end
        EXEC: begin
          res_s     <= add_s;
          res_c     <= flags.c;
          res_v     <= flags.v;
          res_z     <= flags.z;
          res_n     <= flags.n;
          res_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            op_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          op_ready  <= 1'b1;
          res_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_op_sequencer.sv
// Directed bench for addsub_op_sequencer paired with an 8-bit adder/subtractor.
// Accumulator vectors run only when ADDSUB_SEQ_ACC_EN is defined.
module tb_addsub_op_sequencer;
  import addsub_op_sequencer_pkg::*;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         op_valid;
  logic         op_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_sub;
  logic         op_acc;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic         add_cin;
  logic [W-1:0] add_s;
  logic         add_cout;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_s;
  logic         res_c;
  logic         res_v;
  logic         res_z;
  logic         res_n;

  int unsigned n_checks;
  int unsigned n_errors;

  // Stand-in for the team's 8-bit adder/subtractor: S = A + (B ^ Cin) + Cin.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b ^ {W{add_cin}}} + {{W{1'b0}}, add_cin};

  addsub_op_sequencer #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_sub   (op_sub),
    .op_acc   (op_acc),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_s    (add_s),
    .add_cout (add_cout),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_s    (res_s),
    .res_c    (res_c),
    .res_v    (res_v),
    .res_z    (res_z),
    .res_n    (res_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op from IDLE; checks accept, latency and the captured result.
  // With res_ready high the result is consumed on the following edge.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic acc,
                        input logic [W-1:0] exp_a, input logic [W-1:0] exp_s,
                        input logic [3:0] exp_cvzn);
    @(negedge clk);
    check({tag, "_ready_before"}, {31'd0, op_ready}, 32'd1);
    op_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    op_sub   = sub;
    op_acc   = acc;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op_acc   = 1'b0;
    check({tag, "_add_a"}, {24'd0, add_a}, {24'd0, exp_a});
    check({tag, "_add_b_cin"}, {23'd0, add_cin, add_b}, {23'd0, sub, b});
    check({tag, "_exec_ready_valid"}, {30'd0, op_ready, res_valid}, 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_res_valid"}, {31'd0, res_valid}, 32'd1);
    check({tag, "_res_s"}, {24'd0, res_s}, {24'd0, exp_s});
    check({tag, "_cvzn"}, {28'd0, res_c, res_v, res_z, res_n}, {28'd0, exp_cvzn});
    if (res_ready) begin
      @(posedge clk);
      #1;
      check({tag, "_consumed"}, {30'd0, res_valid, op_ready}, 32'd1);
      check({tag, "_res_s_held"}, {24'd0, res_s}, {24'd0, exp_s});
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    op_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_sub    = MODE_ADD;
    op_acc    = 1'b0;
    res_ready = 1'b1;
    #12;
    check("reset_outputs", {res_valid, op_ready, res_c, res_v, res_z, res_n, add_cin, res_s, add_a, add_b},
          {7'b0100000, 24'd0});
    rst_n = 1'b1;

    // Basic add / subtract / overflow vectors (expected cvzn hand-computed).
    run_op("add_05_03", 8'h05, 8'h03, MODE_ADD, 1'b0, 8'h05, 8'h08, 4'b0000);
    run_op("sub_05_05", 8'h05, 8'h05, MODE_SUB, 1'b0, 8'h05, 8'h00, 4'b1010);
    run_op("sub_03_05", 8'h03, 8'h05, MODE_SUB, 1'b0, 8'h03, 8'hFE, 4'b0001);
    run_op("add_7f_01", 8'h7F, 8'h01, MODE_ADD, 1'b0, 8'h7F, 8'h80, 4'b0101);
    run_op("sub_80_01", 8'h80, 8'h01, MODE_SUB, 1'b0, 8'h80, 8'h7F, 4'b1100);

    // Backpressure: 0xA0 + 0x70 = 0x110 -> s=0x10, c=1.
    res_ready = 1'b0;
    run_op("bp_a0_70", 8'hA0, 8'h70, MODE_ADD, 1'b0, 8'hA0, 8'h10, 4'b1000);
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clk);
      op_valid = 1'b1;
      op_a     = 8'h11 + 8'(i);
      op_b     = 8'h22;
      op_sub   = MODE_SUB;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      check("bp_hold_flags", {28'd0, res_valid, op_ready, res_c, res_z}, {28'd0, 4'b1010});
      check("bp_hold_data", {8'd0, res_s, add_a, add_b}, {8'd0, 8'h10, 8'hA0, 8'h70});
    end
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release", {30'd0, res_valid, op_ready}, 32'd1);
    check("bp_release_s", {24'd0, res_s}, 32'h10);

    // Reset while in EXEC drops the operation immediately.
    @(negedge clk);
    op_valid = 1'b1;
    op_a     = 8'h7F;
    op_b     = 8'h01;
    op_sub   = MODE_ADD;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    check("rst_in_exec_pre", {31'd0, op_ready}, 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs", {res_valid, op_ready, res_c, res_v, res_z, res_n, add_cin, res_s, add_a, add_b},
          {7'b0100000, 24'd0});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_idle_after", {30'd0, res_valid, op_ready}, 32'd1);

`ifdef ADDSUB_SEQ_ACC_EN
    run_op("acc_first", 8'h10, 8'h00, MODE_ADD, 1'b0, 8'h10, 8'h10, 4'b0000);
    run_op("acc_add", 8'hEE, 8'h20, MODE_ADD, 1'b1, 8'h10, 8'h30, 4'b0000);
    run_op("acc_sub", 8'hEE, 8'h40, MODE_SUB, 1'b1, 8'h30, 8'hF0, 4'b0001);
`else
    run_op("acc_ignored", 8'h10, 8'h20, MODE_ADD, 1'b1, 8'h10, 8'h30, 4'b0000);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
